// File: rtl/avg_sequencer_if.sv
// Byte-wide data-memory port used by the averaging sequencer.
// The sequencer is the master; the memory (DM1) is the slave.
interface avg_sequencer_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/avg_sequencer.sv
// Fixed-point (8.8) averaging accelerator: reads N values from DM1, sums them,
// divides by N with a bit-serial restoring divider and writes the 8.8 result back.
module avg_sequencer #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DIV_BITS = 24
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic              Err,
  output logic              busy,
  avg_sequencer_if.master   mem
);

  localparam int unsigned N_W   = 8;
  localparam int unsigned CNT_W = $clog2(DIV_BITS);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_N, S_CAP_N, S_RD_B, S_ACC, S_DIV, S_WR_HI, S_WR_LO, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  start_q;
  logic [N_W-1:0]        n_q, n_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [DIV_BITS-1:0]   sum_q, sum_d;
  logic [DIV_BITS-1:0]   div_q, div_d;
  logic [N_W-1:0]        rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            res_lo_q, res_lo_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  // One restoring-division step: shift in the dividend MSB, subtract N if it fits
  logic [N_W:0]          partial_c;
  logic                  fits_c;
  logic [N_W-1:0]        rem_nxt_c;
  logic [DIV_BITS-1:0]   quot_nxt_c;
  logic [ADDR_W-1:0]     two_n_c;
  logic [ADDR_W-1:0]     hi_addr_c;
  logic [ADDR_W-1:0]     lo_addr_c;

  always_comb begin
    partial_c  = {rem_q, div_q[DIV_BITS-1]};
    fits_c     = (partial_c >= {1'b0, n_q});
    rem_nxt_c  = fits_c ? N_W'(partial_c - {1'b0, n_q}) : N_W'(partial_c);
    quot_nxt_c = {div_q[DIV_BITS-2:0], fits_c};
    two_n_c    = ADDR_W'(n_q) << 1;
    hi_addr_c  = two_n_c + ADDR_W'(1);
    lo_addr_c  = two_n_c + ADDR_W'(2);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      n_q      <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= Start;
      n_q      <= n_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // Memory strobes are registered, so each is set on the edge entering its state
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    div_d    = div_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_en_d  = 1'b0;
    wr_en_d  = 1'b0;
    ack_d    = ack_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_q && !Start) begin
          state_d = S_RD_N;
          addr_d  = '0;
          rd_en_d = 1'b1;
          n_d     = '0;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      S_RD_N: state_d = S_CAP_N;
      S_CAP_N: begin
        n_d = mem.mem_rdata;
        if (mem.mem_rdata == '0) begin
          state_d  = S_WR_HI;
          addr_d   = ADDR_W'(1);
          wdata_d  = '0;
          res_lo_d = '0;
          wr_en_d  = 1'b1;
        end else begin
          state_d = S_RD_B;
          idx_d   = ADDR_W'(1);
          addr_d  = ADDR_W'(1);
          rd_en_d = 1'b1;
        end
      end
      S_RD_B: state_d = S_ACC;
      S_ACC: begin
        // Odd addresses hold integer bytes, even addresses fraction bytes
        sum_d = sum_q + (idx_q[0] ? DIV_BITS'({mem.mem_rdata, 8'h00})
                                  : DIV_BITS'(mem.mem_rdata));
        if (idx_q == two_n_c) begin
          state_d = S_DIV;
          div_d   = sum_d;
          rem_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_RD_B;
          idx_d   = idx_q + ADDR_W'(1);
          addr_d  = idx_d;
          rd_en_d = 1'b1;
        end
      end
      S_DIV: begin
        div_d = quot_nxt_c;
        rem_d = rem_nxt_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_BITS - 1)) begin
          state_d  = S_WR_HI;
          addr_d   = hi_addr_c;
          wdata_d  = quot_nxt_c[15:8];
          res_lo_d = quot_nxt_c[7:0];
          wr_en_d  = 1'b1;
        end
      end
      S_WR_HI: begin
        state_d = S_WR_LO;
        addr_d  = lo_addr_c;
        wdata_d = res_lo_q;
        wr_en_d = 1'b1;
      end
      S_WR_LO: begin
        state_d = S_DONE;
        ack_d   = 1'b1;
        err_d   = (n_q == '0);
      end
      S_DONE: begin
        if (Start) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = !((state_d == S_IDLE) || (state_d == S_DONE));
  end

  assign Ack           = ack_q;
  assign Err           = err_q;
  assign busy          = busy_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_rd_en = rd_en_q;
  assign mem.mem_wr_en = wr_en_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_avg_sequencer.sv
// Bench for avg_sequencer: DM1 model, directed and random runs checked
// against an arithmetic average model.
module tb_avg_sequencer;

  logic Clk;
  logic Reset;
  logic Start;
  logic Ack;
  logic Err;
  logic busy;

  avg_sequencer_if #(.ADDR_W(10)) mif ();

  avg_sequencer #(.ADDR_W(10), .DIV_BITS(24)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack),
    .Err   (Err),
    .busy  (busy),
    .mem   (mif.master)
  );

  logic [7:0]  mem [0:1023];
  logic [15:0] vals [0:254];
  int          wr_count;
  bit          overlap;
  int          checks;
  int          failures;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // DM1 model: synchronous write, one-cycle read latency
  always @(posedge Clk) begin
    if (mif.mem_rd_en && mif.mem_wr_en) overlap = 1'b1;
    if (mif.mem_wr_en) begin
      mem[mif.mem_addr] = mif.mem_wdata;
      wr_count = wr_count + 1;
    end
    if (mif.mem_rd_en) mif.mem_rdata <= mem[mif.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"},   32'(Ack), 32'd0);
    check({tag, "_err"},   32'(Err), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_rd_en"}, 32'(mif.mem_rd_en), 32'd0);
    check({tag, "_wr_en"}, 32'(mif.mem_wr_en), 32'd0);
    check({tag, "_addr"},  32'(mif.mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mif.mem_wdata), 32'd0);
  endtask

  // Preload N and vals[0..N-1], launch, and compare against floor(sum/N)
  task automatic run_avg(input int n, input bit toggle, input int abort_at);
    int sum;
    int exp_res;
    int exp_lat;
    int cycles;
    bit done;
    sum = 0;
    @(negedge Clk);
    Start = 1'b1;
    mem[0] = 8'(n);
    for (int i = 0; i < n; i++) begin
      mem[2*i+1] = vals[i][15:8];
      mem[2*i+2] = vals[i][7:0];
      sum = sum + int'(vals[i]);
    end
    mem[2*n+1] = 8'hA5;
    mem[2*n+2] = 8'hA5;
    exp_res = (n == 0) ? 0 : (sum / n) % 65536;
    exp_lat = (n == 0) ? 4 : 4*n + 28;
    wr_count = 0;
    repeat (2) @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    #1;
    check("busy_after_start", 32'(busy), 32'd1);
    check("rd_n_strobe", {31'd0, mif.mem_rd_en}, 32'd1);
    check("rd_n_addr", 32'(mif.mem_addr), 32'd0);
    cycles = 0;
    done = 1'b0;
    while (!done && cycles < 3000) begin
      @(posedge Clk);
      #1;
      cycles++;
      if (toggle && cycles == 10) Start = 1'b1;
      if (toggle && cycles == 13) Start = 1'b0;
      if (abort_at > 0 && cycles == abort_at) begin
        Reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (3) @(posedge Clk);
        #1;
        check("abort_hi_untouched", 32'(mem[2*n+1]), 32'hA5);
        check("abort_lo_untouched", 32'(mem[2*n+2]), 32'hA5);
        check("abort_no_writes", 32'(wr_count), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        return;
      end
      if (Ack) done = 1'b1;
    end
    check("ack_latency", 32'(cycles), 32'(exp_lat));
    check("err_flag", 32'(Err), (n == 0) ? 32'd1 : 32'd0);
    check("result_hi", 32'(mem[2*n+1]), 32'((exp_res >> 8) & 255));
    check("result_lo", 32'(mem[2*n+2]), 32'(exp_res & 255));
    check("write_count", 32'(wr_count), 32'd2);
    check("busy_in_done", 32'(busy), 32'd0);
    repeat (3) @(posedge Clk);
    #1;
    check("ack_hold", 32'(Ack), 32'd1);
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    check("ack_clear", 32'(Ack), 32'd0);
    check("err_clear", 32'(Err), 32'd0);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    wr_count = 0;
    overlap  = 1'b0;
    Reset    = 1'b0;
    Start    = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    check_idle_outputs("reset");
    @(negedge Clk);
    Reset = 1'b1;

    // Integers 1..9
    for (int i = 0; i < 9; i++) vals[i] = 16'((i + 1) << 8);
    run_avg(9, 1'b0, 0);

    // Powers of two -> 10.5
    for (int i = 0; i < 6; i++) vals[i] = 16'((1 << i) << 8);
    run_avg(6, 1'b0, 0);

    // Fraction-byte accumulation with carry into the integer part
    vals[0] = 16'h0000;
    vals[1] = 16'h4080;
    vals[2] = 16'h8080;
    vals[3] = 16'h8080;
    run_avg(4, 1'b0, 0);

    // Empty list
    run_avg(0, 1'b0, 0);

    // Abort during division, then a clean rerun
    for (int i = 0; i < 9; i++) vals[i] = 16'((i + 1) << 8);
    run_avg(9, 1'b0, 50);
    run_avg(9, 1'b0, 0);

    // Largest list, Start toggled mid-run
    for (int i = 0; i < 255; i++) vals[i] = 16'hFFFF;
    run_avg(255, 1'b1, 0);

    // Random lists
    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) vals[i] = 16'($urandom);
      run_avg(n, r[0], 0);
    end

    check("rdwr_exclusive", 32'(overlap), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
